// File: rtl/median_7_seq_ctrl.sv
// Sequential 7-word sorter: one compare-exchange per cycle over a fixed 16-step network.
// Define MEDIAN7_PERF_CNT_EN to add the 16-bit jobs_done handshake counter.
module median_7_seq_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic [DATA_W-1:0] data_4,
    input  logic [DATA_W-1:0] data_5,
    input  logic [DATA_W-1:0] data_6,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sort_0,
    output logic [DATA_W-1:0] sort_1,
    output logic [DATA_W-1:0] sort_2,
    output logic [DATA_W-1:0] sort_3,
    output logic [DATA_W-1:0] sort_4,
    output logic [DATA_W-1:0] sort_5,
    output logic [DATA_W-1:0] sort_6,
    output logic              busy
`ifdef MEDIAN7_PERF_CNT_EN
    ,
    output logic [15:0]       jobs_done
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [3:0]        step_q;
    logic [DATA_W-1:0] w_q [7];
    logic              in_ready_q, out_valid_q, busy_q;

    logic [2:0]        idx_lo, idx_hi;
    logic [DATA_W-1:0] lo_val, hi_val;
    logic              do_swap;

    // Optimal 7-input sorting network, serialised one comparator per step.
    always_comb begin
        idx_lo = 3'd0;
        idx_hi = 3'd0;
        case (step_q)
            4'd0:  begin idx_lo = 3'd0; idx_hi = 3'd6; end
            4'd1:  begin idx_lo = 3'd2; idx_hi = 3'd3; end
            4'd2:  begin idx_lo = 3'd4; idx_hi = 3'd5; end
            4'd3:  begin idx_lo = 3'd0; idx_hi = 3'd2; end
            4'd4:  begin idx_lo = 3'd1; idx_hi = 3'd4; end
            4'd5:  begin idx_lo = 3'd3; idx_hi = 3'd6; end
            4'd6:  begin idx_lo = 3'd0; idx_hi = 3'd1; end
            4'd7:  begin idx_lo = 3'd2; idx_hi = 3'd5; end
            4'd8:  begin idx_lo = 3'd3; idx_hi = 3'd4; end
            4'd9:  begin idx_lo = 3'd1; idx_hi = 3'd2; end
            4'd10: begin idx_lo = 3'd4; idx_hi = 3'd6; end
            4'd11: begin idx_lo = 3'd2; idx_hi = 3'd3; end
            4'd12: begin idx_lo = 3'd4; idx_hi = 3'd5; end
            4'd13: begin idx_lo = 3'd1; idx_hi = 3'd2; end
            4'd14: begin idx_lo = 3'd3; idx_hi = 3'd4; end
            default: begin idx_lo = 3'd5; idx_hi = 3'd6; end
        endcase
        lo_val  = w_q[idx_lo];
        hi_val  = w_q[idx_hi];
        do_swap = lo_val > hi_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_q      <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 7; i++) w_q[i] <= '0;
        end else if (flush) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        w_q[0]     <= data_0;
                        w_q[1]     <= data_1;
                        w_q[2]     <= data_2;
                        w_q[3]     <= data_3;
                        w_q[4]     <= data_4;
                        w_q[5]     <= data_5;
                        w_q[6]     <= data_6;
                        step_q     <= 4'd0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    if (do_swap) begin
                        w_q[idx_lo] <= hi_val;
                        w_q[idx_hi] <= lo_val;
                    end
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'd15) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEDIAN7_PERF_CNT_EN
    logic [15:0] jobs_done_q;

    // Flush wins over a same-cycle handshake, so it never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jobs_done_q <= 16'd0;
        end else if (!flush && out_valid_q && out_ready) begin
            jobs_done_q <= jobs_done_q + 16'd1;
        end
    end

    assign jobs_done = jobs_done_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sort_0    = w_q[0];
    assign sort_1    = w_q[1];
    assign sort_2    = w_q[2];
    assign sort_3    = w_q[3];
    assign sort_4    = w_q[4];
    assign sort_5    = w_q[5];
    assign sort_6    = w_q[6];

endmodule

// File: tb/tb_median_7_seq_ctrl.sv
// Self-checking bench for median_7_seq_ctrl: vector table, scoreboard queue, corner sequences.
// The jobs_done checks build only when MEDIAN7_PERF_CNT_EN is defined.
module tb_median_7_seq_ctrl;

    typedef logic [6:0][31:0] word7_t;
    typedef struct {
        word7_t d;
        word7_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    word7_t      din = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] s0, s1, s2, s3, s4, s5, s6;
    word7_t      got;
`ifdef MEDIAN7_PERF_CNT_EN
    logic [15:0] jobs_done;
`endif

    int     pass_cnt = 0;
    int     total_cnt = 0;
    int     hs_cnt = 0;
    word7_t exp_q[$];
    vec_t   vecs[6];

    always #5 clk = ~clk;

    assign got = {s6, s5, s4, s3, s2, s1, s0};

    median_7_seq_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_0(din[0]), .data_1(din[1]), .data_2(din[2]), .data_3(din[3]),
        .data_4(din[4]), .data_5(din[5]), .data_6(din[6]),
        .out_valid(out_valid), .out_ready(out_ready),
        .sort_0(s0), .sort_1(s1), .sort_2(s2), .sort_3(s3),
        .sort_4(s4), .sort_5(s5), .sort_6(s6),
        .busy(busy)
`ifdef MEDIAN7_PERF_CNT_EN
        , .jobs_done(jobs_done)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic word7_t w7(input logic [31:0] a0, a1, a2, a3, a4, a5, a6);
        word7_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5; r[6] = a6;
        return r;
    endfunction

    function automatic word7_t ref_sort(input word7_t a);
        word7_t      r = a;
        logic [31:0] t;
        for (int i = 1; i < 7; i++)
            for (int j = i; j > 0; j--)
                if (r[j-1] > r[j]) begin
                    t = r[j]; r[j] = r[j-1]; r[j-1] = t;
                end
        return r;
    endfunction

    function automatic logic [2:0] ctrl();
        return {in_ready, out_valid, busy};
    endfunction

    task automatic start_job(input word7_t d, input word7_t e, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready before accept", in_ready, 1);
        in_valid = 1'b1;
        din      = d;
        tick();
        in_valid = 1'b0;
        din      = ~d;
        check("ctrl after accept", ctrl(), 3'b001);
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 16);
    endtask

    task automatic wait_result(input string name);
        int     lat;
        word7_t e;
        wait_valid(lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (out_valid) begin
            out_ready = 1'b1;
            check(name, got, e);
            tick();
            out_ready = 1'b0;
            hs_cnt++;
            check("idle after handshake", ctrl(), 3'b100);
        end
    endtask

    initial begin
        int     lat;
        int     cyc;
        bit     seen;
        word7_t d;
        word7_t e;
`ifdef MEDIAN7_PERF_CNT_EN
        logic [15:0] jd_before;
`endif

        vecs[0].d = w7(7, 6, 5, 4, 3, 2, 1);
        vecs[0].e = w7(1, 2, 3, 4, 5, 6, 7);
        vecs[1].d = w7(5, 5, 0, 32'hFFFF_FFFF, 5, 0, 5);
        vecs[1].e = w7(0, 0, 5, 5, 5, 5, 32'hFFFF_FFFF);
        vecs[2].d = w7(3, 1, 2, 0, 6, 5, 4);
        vecs[2].e = w7(0, 1, 2, 3, 4, 5, 6);
        vecs[3].d = w7(9, 9, 9, 9, 9, 9, 9);
        vecs[3].e = w7(9, 9, 9, 9, 9, 9, 9);
        vecs[4].d = w7(0, 1, 2, 3, 4, 5, 6);
        vecs[4].e = w7(0, 1, 2, 3, 4, 5, 6);
        vecs[5].d = w7(32'h8000_0000, 32'h7FFF_FFFF, 1, 32'hFFFF_FFFE, 0, 32'h8000_0001, 2);
        vecs[5].e = w7(0, 1, 2, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFE);

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset ctrl", ctrl(), 3'b100);
        check("reset words", got, '0);
`ifdef MEDIAN7_PERF_CNT_EN
        check("reset jobs_done", jobs_done, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_job(vecs[i].d, vecs[i].e, 1'b1);
            wait_result($sformatf("vector %0d", i));
        end

        // Backpressure: result held for 10 cycles, new in_valid ignored.
        start_job(vecs[0].d, vecs[0].e, 1'b1);
        wait_valid(lat);
        in_valid = 1'b1;
        din      = vecs[2].d;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp words stable", got, vecs[0].e);
            check("bp ctrl", ctrl(), 3'b010);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        hs_cnt++;
        void'(exp_q.pop_front());
        check("bp release idle", ctrl(), 3'b100);
        start_job(vecs[2].d, vecs[2].e, 1'b1);
        wait_result("job after bp");

        // Flush at step 8, then flush racing in_valid in IDLE.
`ifdef MEDIAN7_PERF_CNT_EN
        jd_before = jobs_done;
`endif
        start_job(vecs[1].d, vecs[1].e, 1'b0);
        repeat (8) tick();
        check("busy before flush", ctrl(), 3'b001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush to idle", ctrl(), 3'b100);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("no out_valid after flush", seen, 0);
`ifdef MEDIAN7_PERF_CNT_EN
        check("jobs_done kept on flush", jobs_done, jd_before);
`endif
        flush    = 1'b1;
        in_valid = 1'b1;
        din      = vecs[0].d;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush beats in_valid", ctrl(), 3'b100);
        start_job(vecs[5].d, vecs[5].e, 1'b1);
        wait_result("job after flush");

        // Asynchronous reset mid-RUN.
        start_job(vecs[0].d, vecs[0].e, 1'b0);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid-run reset ctrl", ctrl(), 3'b100);
        check("mid-run reset words", got, '0);
        hs_cnt = 0;
`ifdef MEDIAN7_PERF_CNT_EN
        check("mid-run reset jobs_done", jobs_done, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        start_job(vecs[2].d, vecs[2].e, 1'b1);
        wait_result("job after reset");

        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 7; k++)
                d[k] = (n % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            e = ref_sort(d);
            start_job(d, e, 1'b1);
            wait_result("random job");
        end

`ifdef MEDIAN7_PERF_CNT_EN
        check("jobs_done count", jobs_done, 32'(hs_cnt[15:0]));
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        hs_cnt    = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc       = 0;
        while (hs_cnt < 65537 && cyc < 65537 * 18 + 100) begin
            tick();
            cyc++;
            if (out_valid) begin
                hs_cnt++;
                if (hs_cnt == 65537) in_valid = 1'b0;
            end
        end
        tick();
        tick();
        out_ready = 1'b0;
        check("wrap job count", hs_cnt, 65537);
        check("jobs_done wrap", jobs_done, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
